// File: rtl/lzd_chunk_scanner.sv
// Multi-cycle leading-zero count and normalize of a 16*NCHUNK-bit word.
// One shared 16-bit LZD is stepped MSB-chunk first; the word is then shifted so its MSB is 1.

module LZD_16 (
  input  logic [15:0] data,
  output logic [4:0]  zeros
);
  // Last hit wins, so the highest set bit determines the count.
  always_comb begin
    zeros = 5'd16;
    for (int i = 0; i < 16; i++) begin
      if (data[i]) zeros = 5'(15 - i);
    end
  end
endmodule

module lzd_chunk_scanner #(
  parameter int NCHUNK = 3,
  parameter int LZC_W  = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [16*NCHUNK-1:0] in_word,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LZC_W-1:0]     lzc,
  output logic [16*NCHUNK-1:0] norm,
  output logic                 busy
);
  localparam int W     = 16 * NCHUNK;
  localparam int IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

  state_t           state;
  logic [W-1:0]     word_r;
  logic [W-1:0]     norm_r;
  logic [LZC_W-1:0] acc;
  logic [LZC_W-1:0] lzc_r;
  logic [IDX_W-1:0] idx;
  logic [15:0]      lzd_in;
  logic [4:0]       z;
  logic [LZC_W-1:0] z_ext;

  // The detector sees zeros outside SCAN so it never toggles needlessly.
  always_comb begin
    lzd_in = 16'h0000;
    if (state == SCAN) begin
      for (int c = 0; c < NCHUNK; c++) begin
        if (idx == IDX_W'(c)) lzd_in = word_r[W-1-16*c -: 16];
      end
    end
  end

  LZD_16 u_lzd (
    .data  (lzd_in),
    .zeros (z)
  );

  assign z_ext = LZC_W'(z);
  assign lzc   = lzc_r;
  assign norm  = norm_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      word_r    <= '0;
      norm_r    <= '0;
      acc       <= '0;
      lzc_r     <= '0;
      idx       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            word_r   <= in_word;
            acc      <= '0;
            idx      <= '0;
            state    <= SCAN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SCAN: begin
          if (z != 5'd16) begin
            lzc_r <= acc + z_ext;
            state <= SHIFT;
          end else if (idx != IDX_W'(NCHUNK - 1)) begin
            acc <= acc + LZC_W'(16);
            idx <= idx + 1'b1;
          end else begin
            lzc_r <= LZC_W'(W);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          norm_r    <= word_r << lzc_r;
          state     <= DONE;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lzd_chunk_scanner.sv
// Scoreboard bench for lzd_chunk_scanner: expected results queued at accept, compared at out_valid.

module tb_lzd_chunk_scanner;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  lzc;
  logic [47:0] norm;
  logic        busy;

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    logic [5:0]  lzc;
    logic [47:0] norm;
    int          lat;
    int          period;
  } exp_t;

  exp_t sb[$];

  lzd_chunk_scanner dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lzc       (lzc),
    .norm      (norm),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [47:0] w);
    exp_t e;
    int   n = 48;
    int   j;
    for (int i = 0; i < 48; i++) if (w[i]) n = 47 - i;
    j = n / 16;
    if (j > 2) j = 2;
    e.lzc    = 6'(n);
    e.norm   = (n == 48) ? 48'h0 : (w << n);
    e.lat    = j + 2;
    e.period = j + 4;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one word, wait for its result, compare, then release with out_ready.
  task automatic run_word(input logic [47:0] w, input string name);
    exp_t e;
    int   cyc = 0;
    in_valid  = 1'b1;
    in_word   = w;
    out_ready = 1'b0;
    sb.push_back(model(w));
    step();
    in_valid = 1'b0;
    while (!out_valid && cyc < 20) begin
      step();
      cyc++;
    end
    e = sb.pop_front();
    vectors++;
    if (!out_valid) begin
      errors++;
      $display("FAIL %s timeout: out_valid=%b after %0d cycles, required 1", name, out_valid, cyc);
    end
    vectors++;
    if (cyc !== e.lat) begin
      errors++;
      $display("FAIL %s latency: got %0d, required %0d", name, cyc, e.lat);
    end
    vectors++;
    if (lzc !== e.lzc) begin
      errors++;
      $display("FAIL %s lzc: got %0d, required %0d", name, lzc, e.lzc);
    end
    vectors++;
    if (norm !== e.norm) begin
      errors++;
      $display("FAIL %s norm: got %h, required %h", name, norm, e.norm);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s release: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
               name, in_ready, out_valid, busy);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_word   = '0;
    out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || lzc !== 6'd0 || norm !== 48'h0) begin
      errors++;
      $display("FAIL reset state: in_ready=%b out_valid=%b busy=%b lzc=%0d norm=%h, required 1 0 0 0 0",
               in_ready, out_valid, busy, lzc, norm);
    end
  endtask

  task automatic test_vectors();
    logic [47:0] w;
    run_word(48'h8000_0000_0000, "msb_set");
    run_word(48'h0000_1234_5678, "chunk1");
    run_word(48'h0000_0000_0001, "lsb_only");
    run_word(48'h0000_0000_0000, "all_zero");
    run_word(48'hFFFF_FFFF_FFFF, "all_ones");
    run_word(48'h0000_8000_0000, "chunk1_msb");
    for (int k = 0; k < 6; k++) begin
      w = {$urandom, $urandom} >> 16;
      w = w >> $urandom_range(0, 47);
      run_word(w, "random");
    end
  endtask

  task automatic test_backpressure();
    logic [5:0]  lzc_hold;
    logic [47:0] norm_hold;
    int          cyc = 0;
    exp_t        e;
    in_valid  = 1'b1;
    in_word   = 48'h0000_0F00_0000;
    out_ready = 1'b0;
    sb.push_back(model(in_word));
    step();
    in_valid = 1'b0;
    while (!out_valid && cyc < 20) begin
      step();
      cyc++;
    end
    e = sb.pop_front();
    vectors++;
    if (!out_valid || lzc !== e.lzc || norm !== e.norm) begin
      errors++;
      $display("FAIL bp result: out_valid=%b lzc=%0d norm=%h, required 1 %0d %h",
               out_valid, lzc, norm, e.lzc, e.norm);
    end
    lzc_hold  = lzc;
    norm_hold = norm;
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      in_word  = 48'h8000_0000_0000;
      step();
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || lzc !== lzc_hold || norm !== norm_hold) begin
        errors++;
        $display("FAIL bp hold %0d: out_valid=%b in_ready=%b lzc=%0d norm=%h, required 1 0 %0d %h",
                 k, out_valid, in_ready, lzc, norm, lzc_hold, norm_hold);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    for (int k = 0; k < 6; k++) begin
      step();
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL bp phantom: out_valid=%b busy=%b, required 0 0", out_valid, busy);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    exp_t e;
    in_valid  = 1'b1;
    in_word   = 48'h0000_0000_0001;
    out_ready = 1'b1;
    sb.push_back(model(in_word));
    step();
    in_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    e = sb.pop_front();
    vectors++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || lzc !== 6'd0 || norm !== 48'h0) begin
      errors++;
      $display("FAIL midscan reset: busy=%b in_ready=%b out_valid=%b lzc=%0d norm=%h, required 0 1 0 0 0 (discarded lzc %0d)",
               busy, in_ready, out_valid, lzc, norm, e.lzc);
    end
    for (int k = 0; k < 6; k++) begin
      step();
      vectors++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midscan stale: out_valid=%b, required 0", out_valid);
      end
    end
    run_word(48'h0001_0000_0000, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [47:0] words[6] = '{48'h8000_0000_0001, 48'h0000_0000_0000, 48'h0000_7FFF_0000,
                              48'h4000_0000_0000, 48'h0000_0000_00FF, 48'h0001_0000_0000};
    exp_t e;
    int   sent = 0;
    int   got = 0;
    int   last_acc = 0;
    int   prev_period = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int cyc = 0; cyc < 200 && got < 6; cyc++) begin
      if (out_valid) begin
        vectors++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL b2b unexpected output lzc=%0d norm=%h", lzc, norm);
        end else begin
          e = sb.pop_front();
          if (lzc !== e.lzc || norm !== e.norm) begin
            errors++;
            $display("FAIL b2b result %0d: lzc=%0d norm=%h, required %0d %h", got, lzc, norm, e.lzc, e.norm);
          end
        end
        got++;
      end
      if (in_ready && sent < 6) begin
        in_valid = 1'b1;
        in_word  = words[sent];
        if (sent > 0) begin
          vectors++;
          if (cyc - last_acc !== prev_period) begin
            errors++;
            $display("FAIL b2b spacing %0d: got %0d cycles, required %0d", sent, cyc - last_acc, prev_period);
          end
        end
        last_acc    = cyc;
        prev_period = model(words[sent]).period;
        sb.push_back(model(words[sent]));
        sent++;
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    vectors++;
    if (got !== 6) begin
      errors++;
      $display("FAIL b2b count: got %0d results, required 6", got);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_scan();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/lzd_chunk_scanner.md
# lzd_chunk_scanner

Multi-cycle leading-zero counter and normalizer for 48-bit uniform samples in the AWGN generator's log/sqrt front end. It scans the input word MSB-first in 16-bit chunks and time-shares a single instance of the existing 16-bit leading zero detector (`LZD_16`) across those chunks. It accumulates the zero count, then left-shifts the word so its MSB is 1. It sits between the uniform RNG and the log-approximation stage, with valid/ready handshakes on both sides.

## Interface
- `NCHUNK`, default 3: number of 16-bit chunks. Word width is W = 16*NCHUNK; only 3 is verified.
- `LZC_W`, default 6: count width; must satisfy 2^LZC_W > W.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `in_valid`  in  1: `in_word` is valid.
- `in_ready`  out  1: block can accept a word.
- `in_word`  in  W: sample to normalize.
- `out_valid`  out  1: `lzc` and `norm` are valid.
- `out_ready`  in  1: consumer accepts the result.
- `lzc`  out  LZC_W: leading zero count of the accepted word, range 0..W.
- `norm`  out  W: accepted word shifted left by `lzc`, zero-filled.
- `busy`  out  1: state is not IDLE.

## Operation
- FSM states: IDLE, SCAN, SHIFT, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&`in_ready`: register `in_word` into `word_r`, clear `acc` and `idx`, go to SCAN.
- **SCAN**
  - Chunk `idx` (0 = MSB chunk, `word_r[W-1-16*idx -: 16]`) drives the shared `LZD_16`, giving z = 0..16.
  - If z==16 and `idx`<NCHUNK-1: `acc`+=16, `idx`+=1, stay in SCAN.
  - If z<16: `lzc_r`=`acc`+z, go to SHIFT.
  - If z==16 and `idx`==NCHUNK-1: `lzc_r`=W, go to SHIFT.
- **SHIFT**
  - `norm_r` = `word_r` << `lzc_r` (W-bit result; shift by W gives 0).
  - Go to DONE.
- **DONE**
  - `out_valid`=1; `lzc` and `norm` are stable.
  - On `out_ready`: go to IDLE.
- Exactly one `LZD_16` instance. Its input is driven only in SCAN; in all other states it is driven to 16'h0000.
- `in_ready` is high only in IDLE. `in_valid` in any other state is ignored and is not queued.
- Width rules:
  - `acc` and `lzc_r` are LZC_W bits and never overflow (maximum W).
  - z is zero-extended before the add.

## Timing
- Reset values: `in_ready`=1 (IDLE), `out_valid`=0, `busy`=0, `lzc`=0, `norm`=0.
- Internal reset values: `acc`=0, `idx`=0.
- Accept edge E0. First nonzero chunk index j (j=NCHUNK-1 if the word is all zero):
  - SCAN occupies cycles E0..E(j+1).
  - SHIFT is entered at E(j+1).
  - `out_valid` rises after E(j+2).
- Latency from accept to `out_valid`:
  - 2 cycles for j=0.
  - 4 cycles for j=2 or an all-zero word.
- `out_valid`&`out_ready` at edge Ek:
  - State returns to IDLE, so `in_ready`=1 and `out_valid`=0 after Ek.
  - Next accept is no earlier than Ek+1.
  - `lzc` and `norm` keep their last values until the next SHIFT/SCAN update.
- `out_ready` held low: DONE persists indefinitely and outputs do not change.
- `reset` in any state: next state is IDLE, all outputs take their reset values, and the in-flight word is discarded with no result.
- Throughput with `out_ready` tied high: one word per (j+4) cycles.

## Test plan
- `in_word`=48'h8000_0000_0000 -> `lzc`=0, `norm`=48'h8000_0000_0000, `out_valid` 2 cycles after accept.
- `in_word`=48'h0000_1234_5678 -> `lzc`=19, `norm`=48'h91A2_B3C0_0000, `out_valid` 3 cycles after accept.
- `in_word`=48'h0000_0000_0001 -> `lzc`=47, `norm`=48'h8000_0000_0000, 4 cycles.
- `in_word`=0 -> `lzc`=48, `norm`=0, 4 cycles; `lzc` must not wrap.
- Backpressure: `out_ready`=0 for 5 cycles after `out_valid`, with `in_valid` pulsed meanwhile.
  - `out_valid`, `lzc` and `norm` stay constant.
  - `in_ready` stays 0 and the pulsed words are never accepted.
  - After `out_ready`=1 for one edge, `in_ready`=1.
- Reset mid-SCAN: accept 48'h0000_0000_0001, assert `reset` for one cycle during SCAN.
  - Next cycle: IDLE, `out_valid`=0, `lzc`=0, `norm`=0.
  - No stale result appears; a new accept of 48'h0001_0000_0000 gives `lzc`=15, `norm`=48'h8000_0000_0000.
